// File: rtl/c_merge6_nodata_sync_if.sv
// ---------------------------------------------------------------------------
// c_merge6_nodata_sync_if
// Handshake bundle for the six-into-one dataless merge.
//   i_drive0..5  : upstream request pulses (into the merge)
//   o_free0..5   : upstream completion pulses (out of the merge)
//   o_driveNext  : downstream request pulse (out of the merge)
//   i_freeNext   : downstream completion pulse (into the merge)
//   o_sel        : one-hot granted port while busy, 0 when idle
//   o_busy       : transaction in flight
//   o_err        : sticky protocol-violation flag
// Modports: slave = the merge itself, master = whatever surrounds it.
// ---------------------------------------------------------------------------
interface c_merge6_nodata_sync_if;
  logic       i_drive0, i_drive1, i_drive2, i_drive3, i_drive4, i_drive5;
  logic       o_free0, o_free1, o_free2, o_free3, o_free4, o_free5;
  logic       o_driveNext;
  logic       i_freeNext;
  logic [5:0] o_sel;
  logic       o_busy;
  logic       o_err;

  modport slave (
    input  i_drive0, i_drive1, i_drive2, i_drive3, i_drive4, i_drive5,
    input  i_freeNext,
    output o_free0, o_free1, o_free2, o_free3, o_free4, o_free5,
    output o_driveNext, o_sel, o_busy, o_err
  );

  modport master (
    output i_drive0, i_drive1, i_drive2, i_drive3, i_drive4, i_drive5,
    output i_freeNext,
    input  o_free0, o_free1, o_free2, o_free3, o_free4, o_free5,
    input  o_driveNext, o_sel, o_busy, o_err
  );
endinterface

// File: rtl/c_merge6_nodata_sync.sv
// ---------------------------------------------------------------------------
// c_merge6_nodata_sync
// Clocked 6-to-1 merge for dataless drive/free handshake channels. Each
// upstream drive pulse is latched as a pending request; one request at a time
// is granted, forwarded downstream as a single o_driveNext pulse, and once the
// downstream i_freeNext arrives a single o_free pulse goes back to the winner.
//
// Ports:
//   clk  : clock, rising edge
//   rstn : synchronous active-low reset
//   bus  : c_merge6_nodata_sync_if.slave handshake bundle
//
// Build option:
//   CMERGE6_ROUND_ROBIN_EN defined   -> round-robin arbitration starting after
//                                       the last completed port
//   CMERGE6_ROUND_ROBIN_EN undefined -> fixed priority, port 0 highest
// ---------------------------------------------------------------------------
module c_merge6_nodata_sync #(
  parameter int NUM_PORTS = 6
) (
  input logic                       clk,
  input logic                       rstn,
  c_merge6_nodata_sync_if.slave     bus
);

  if (NUM_PORTS != 6) begin : gBadNumPorts
    $error("c_merge6_nodata_sync supports NUM_PORTS == 6 only");
  end

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT} state_t;

  state_t     state, stateNext;
  logic [5:0] drives;
  logic [5:0] pending, pendingNext;
  logic [5:0] selReg, selNext;
  logic [5:0] freeReg, freeNextVec;
  logic [5:0] clrMask;
  logic [5:0] grantOh;
  logic       driveReg, driveOutNext;
  logic       busyReg, busyNext;
  logic       errReg, errNext;
  logic       grantEn;
  logic       complete;
  logic [2:0] searchFrom;

  // Search starts at the port after 'from' and wraps; the first pending hit wins.
  function automatic logic [5:0] pickNext(input logic [5:0] req, input logic [2:0] from);
    logic [5:0] g;
    logic [2:0] idx;
    g   = '0;
    idx = from;
    for (int k = 0; k < 6; k++) begin
      idx = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      if (g == '0 && req[idx]) g[idx] = 1'b1;
    end
    return g;
  endfunction

`ifdef CMERGE6_ROUND_ROBIN_EN
  logic [2:0] last;

  function automatic logic [2:0] ohToIdx(input logic [5:0] oh);
    logic [2:0] r;
    case (oh)
      6'b000010: r = 3'd1;
      6'b000100: r = 3'd2;
      6'b001000: r = 3'd3;
      6'b010000: r = 3'd4;
      6'b100000: r = 3'd5;
      default:   r = 3'd0;
    endcase
    return r;
  endfunction

  assign searchFrom = last;

  always_ff @(posedge clk) begin
    if (!rstn)         last <= 3'd5;
    else if (complete) last <= ohToIdx(selReg);
  end
`else
  // Starting "after port 5" makes the wrap search a plain 0..5 priority scan.
  assign searchFrom = 3'd5;
`endif

  assign drives = {bus.i_drive5, bus.i_drive4, bus.i_drive3,
                   bus.i_drive2, bus.i_drive1, bus.i_drive0};

  assign grantOh = pickNext(pending, searchFrom);

  // Only requests registered on an earlier edge are eligible; granting is also
  // held off while a free pulse is on the wire so the next drive never
  // shares a cycle with it and a completed port gets a full idle cycle.
  assign grantEn = (state == IDLE) && (pending != '0) && (freeReg == '0);

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      pending  <= '0;
      selReg   <= '0;
      freeReg  <= '0;
      driveReg <= 1'b0;
      busyReg  <= 1'b0;
      errReg   <= 1'b0;
    end else begin
      state    <= stateNext;
      pending  <= pendingNext;
      selReg   <= selNext;
      freeReg  <= freeNextVec;
      driveReg <= driveOutNext;
      busyReg  <= busyNext;
      errReg   <= errNext;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    stateNext = state;
    complete  = 1'b0;
    case (state)
      IDLE:  if (grantEn) stateNext = DRIVE;
      // A free already present during the drive cycle completes at once.
      DRIVE: begin
        if (bus.i_freeNext) begin
          complete  = 1'b1;
          stateNext = IDLE;
        end else begin
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (bus.i_freeNext) begin
          complete  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // ---- output / datapath next values ----
  always_comb begin
    selNext      = selReg;
    busyNext     = busyReg;
    driveOutNext = 1'b0;
    freeNextVec  = '0;
    clrMask      = '0;
    if (grantEn) begin
      selNext      = grantOh;
      busyNext     = 1'b1;
      driveOutNext = 1'b1;
    end
    if (complete) begin
      freeNextVec = selReg;
      clrMask     = selReg;
      selNext     = '0;
      busyNext    = 1'b0;
    end
    // A new drive on the winner's clearing edge re-arms it (set beats clear).
    pendingNext = (pending & ~clrMask) | drives;
    // Errors: drive on a still-pending port (request dropped), or a
    // downstream free with nothing in flight.
    errNext = errReg
            | (|(drives & pending & ~clrMask))
            | ((state == IDLE) && bus.i_freeNext);
  end

  assign bus.o_driveNext = driveReg;
  assign bus.o_sel       = selReg;
  assign bus.o_busy      = busyReg;
  assign bus.o_err       = errReg;
  assign bus.o_free0     = freeReg[0];
  assign bus.o_free1     = freeReg[1];
  assign bus.o_free2     = freeReg[2];
  assign bus.o_free3     = freeReg[3];
  assign bus.o_free4     = freeReg[4];
  assign bus.o_free5     = freeReg[5];

endmodule

// File: tb/tb_c_merge6_nodata_sync.sv
// ---------------------------------------------------------------------------
// tb_c_merge6_nodata_sync
// Directed bench for the 6-to-1 dataless merge. Expected grant orders follow
// the build option CMERGE6_ROUND_ROBIN_EN.
// ---------------------------------------------------------------------------
module tb_c_merge6_nodata_sync;
  logic clk;
  logic rstn;
  int   total;
  int   bad;
  int   driveCount;
  int   freeCount;
  int   violations;

  c_merge6_nodata_sync_if bus ();

  c_merge6_nodata_sync #(.NUM_PORTS(6)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] freeVec();
    return {bus.o_free5, bus.o_free4, bus.o_free3, bus.o_free2, bus.o_free1, bus.o_free0};
  endfunction

  // Pulse bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    logic [5:0] f;
    f = freeVec();
    if (bus.o_driveNext) driveCount++;
    freeCount += $countones(f);
    if ($countones(f) > 1 || (bus.o_driveNext && f != '0)) violations++;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setDrives(input logic [5:0] m);
    bus.i_drive0 = m[0];
    bus.i_drive1 = m[1];
    bus.i_drive2 = m[2];
    bus.i_drive3 = m[3];
    bus.i_drive4 = m[4];
    bus.i_drive5 = m[5];
  endtask

  task automatic pulseDrives(input logic [5:0] m);
    setDrives(m);
    step();
    setDrives('0);
  endtask

  task automatic doReset();
    rstn = 1'b0;
    setDrives('0);
    bus.i_freeNext = 1'b0;
    step();
    step();
    rstn = 1'b1;
    driveCount = 0;
    freeCount  = 0;
    violations = 0;
  endtask

  // Wait for the next downstream drive, answer with a free 'lat' cycles later,
  // and check the returned free goes to the granted port.
  task automatic serve(input string tag, input int lat, input logic [5:0] expSel);
    logic [5:0] gotSel;
    for (int i = 0; i < 20 && !bus.o_driveNext; i++) step();
    if (!bus.o_driveNext) begin
      checkVal({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    gotSel = bus.o_sel;
    checkVal({tag, "_sel"}, {26'd0, gotSel}, {26'd0, expSel});
    repeat (lat) step();
    bus.i_freeNext = 1'b1;
    step();
    bus.i_freeNext = 1'b0;
    checkVal({tag, "_free"}, {26'd0, freeVec()}, {26'd0, expSel});
    checkVal({tag, "_busy0"}, {31'd0, bus.o_busy}, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    driveCount = 0;
    freeCount  = 0;
    violations = 0;
    rstn = 1'b0;
    setDrives('0);
    bus.i_freeNext = 1'b0;

    // ---- reset values and a single request on port 2 ----
    rstn = 1'b0;
    step();
    step();
    checkVal("rst_sel",   {26'd0, bus.o_sel}, 32'd0);
    checkVal("rst_busy",  {31'd0, bus.o_busy}, 32'd0);
    checkVal("rst_drive", {31'd0, bus.o_driveNext}, 32'd0);
    checkVal("rst_free",  {26'd0, freeVec()}, 32'd0);
    checkVal("rst_err",   {31'd0, bus.o_err}, 32'd0);
    rstn = 1'b1;
    step();
    pulseDrives(6'b000100);
    checkVal("single_t1_drive", {31'd0, bus.o_driveNext}, 32'd0);
    step();
    checkVal("single_t2_drive", {31'd0, bus.o_driveNext}, 32'd1);
    checkVal("single_t2_sel",   {26'd0, bus.o_sel}, 32'h04);
    checkVal("single_t2_busy",  {31'd0, bus.o_busy}, 32'd1);
    step();
    checkVal("single_wait_drive", {31'd0, bus.o_driveNext}, 32'd0);
    checkVal("single_wait_busy",  {31'd0, bus.o_busy}, 32'd1);
    bus.i_freeNext = 1'b1;
    step();
    bus.i_freeNext = 1'b0;
    checkVal("single_free", {26'd0, freeVec()}, 32'h04);
    checkVal("single_busy", {31'd0, bus.o_busy}, 32'd0);
    checkVal("single_sel0", {26'd0, bus.o_sel}, 32'd0);
    step();
    checkVal("single_free_1cyc", {26'd0, freeVec()}, 32'd0);
    checkVal("single_err", {31'd0, bus.o_err}, 32'd0);

    // ---- all six at once: order 0..5 in either build ----
    doReset();
    pulseDrives(6'b111111);
    for (int k = 0; k < 6; k++) serve($sformatf("burst%0d", k), 3, 6'(1 << k));
    repeat (4) step();
    checkVal("burst_drives", driveCount, 32'd6);
    checkVal("burst_frees",  freeCount, 32'd6);
    checkVal("burst_overlap", violations, 32'd0);
    checkVal("burst_err", {31'd0, bus.o_err}, 32'd0);

    // ---- fairness after port 4 completes with 5, 0, 3 pending ----
    doReset();
    pulseDrives(6'b010000);
    step();
    checkVal("fair_sel4", {26'd0, bus.o_sel}, 32'h10);
    pulseDrives(6'b101001);
    bus.i_freeNext = 1'b1;
    step();
    bus.i_freeNext = 1'b0;
    checkVal("fair_free4", {26'd0, freeVec()}, 32'h10);
`ifdef CMERGE6_ROUND_ROBIN_EN
    serve("fair_a", 1, 6'b100000);
    serve("fair_b", 1, 6'b000001);
    serve("fair_c", 1, 6'b001000);
`else
    serve("fair_a", 1, 6'b000001);
    serve("fair_b", 1, 6'b001000);
    serve("fair_c", 1, 6'b100000);
`endif
    checkVal("fair_err", {31'd0, bus.o_err}, 32'd0);

    // ---- protocol errors ----
    doReset();
    pulseDrives(6'b000010);
    pulseDrives(6'b000010);
    serve("dup", 1, 6'b000010);
    repeat (6) step();
    checkVal("dup_drives", driveCount, 32'd1);
    checkVal("dup_err", {31'd0, bus.o_err}, 32'd1);
    doReset();
    checkVal("idlefree_pre_err", {31'd0, bus.o_err}, 32'd0);
    bus.i_freeNext = 1'b1;
    step();
    bus.i_freeNext = 1'b0;
    checkVal("idlefree_err", {31'd0, bus.o_err}, 32'd1);
    step();
    checkVal("idlefree_sticky", {31'd0, bus.o_err}, 32'd1);

    // ---- free in the drive cycle, then re-drive on the clearing edge ----
    doReset();
    pulseDrives(6'b000100);
    serve("samecyc", 0, 6'b000100);
    for (int i = 0; i < 20 && !bus.o_driveNext; i++) step();
    checkVal("samecyc_nodrive", {31'd0, bus.o_driveNext}, 32'd0);
    pulseDrives(6'b000100);
    for (int i = 0; i < 20 && !bus.o_driveNext; i++) step();
    checkVal("redrive_first", {26'd0, bus.o_sel}, 32'h04);
    step();
    setDrives(6'b000100);
    bus.i_freeNext = 1'b1;
    step();
    setDrives('0);
    bus.i_freeNext = 1'b0;
    checkVal("redrive_free", {26'd0, freeVec()}, 32'h04);
    step();
    checkVal("redrive_gap", {31'd0, bus.o_driveNext}, 32'd0);
    step();
    checkVal("redrive_f3_drive", {31'd0, bus.o_driveNext}, 32'd1);
    serve("redrive_again", 1, 6'b000100);
    checkVal("redrive_err", {31'd0, bus.o_err}, 32'd0);

    // ---- reset during WAIT aborts the transaction ----
    doReset();
    pulseDrives(6'b010000);
    step();
    step();
    checkVal("abort_busy_pre", {31'd0, bus.o_busy}, 32'd1);
    rstn = 1'b0;
    step();
    checkVal("abort_sel",   {26'd0, bus.o_sel}, 32'd0);
    checkVal("abort_busy",  {31'd0, bus.o_busy}, 32'd0);
    checkVal("abort_drive", {31'd0, bus.o_driveNext}, 32'd0);
    checkVal("abort_err",   {31'd0, bus.o_err}, 32'd0);
    rstn = 1'b1;
    freeCount = 0;
    repeat (4) step();
    checkVal("abort_nofree", freeCount, 32'd0);
    pulseDrives(6'b001000);
    checkVal("abort_new_t1", {31'd0, bus.o_driveNext}, 32'd0);
    step();
    checkVal("abort_new_t2", {31'd0, bus.o_driveNext}, 32'd1);
    serve("abort_new", 1, 6'b001000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
